// File: rtl/rggen_bus_initiator_pkg.sv
// rggen_bus_initiator_pkg: helpers local to the bus initiator.
//   lane_mask() : mask of the byte-lane address bits for a given data width
package rggen_bus_initiator_pkg;

   // Address bits that select a byte inside one bus word; all zero when aligned.
   function automatic int unsigned lane_mask(input int unsigned bus_width);
      return (bus_width / 32'd8) - 32'd1;
   endfunction

endpackage

// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared rggen bus encodings.
//   rggen_access : bus access kind (read / posted write / write)
//   rggen_status : slave response status
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_READ         = 2'b00,
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_WRITE        = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: rggen register bus.
//   master : drives valid/access/address/write_data/strobe, samples ready/status/read_data
//   slave  : the mirror image
interface rggen_bus_if
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
);
   logic                     valid;
   rggen_access              access;
   logic [ADDRESS_WIDTH-1:0] address;
   logic [BUS_WIDTH-1:0]     write_data;
   logic [BUS_WIDTH/8-1:0]   strobe;
   logic                     ready;
   rggen_status              status;
   logic [BUS_WIDTH-1:0]     read_data;

   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );

   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );
endinterface

// File: rtl/rggen_bus_initiator_sva.sv
// rggen_bus_initiator_sva: handshake properties of the bus initiator.
//   bus side      : fields stable while valid waits for ready
//   response side : status/data stable while valid waits for ready
//   command side  : command ready and response valid are exclusive
module rggen_bus_initiator_sva #(
   parameter int BUS_FIELDS_WIDTH = 1,
   parameter int RSP_FIELDS_WIDTH = 1
)(
   input logic                        i_clk,
   input logic                        i_rst_n,
   input logic                        i_bus_valid,
   input logic                        i_bus_ready,
   input logic [BUS_FIELDS_WIDTH-1:0] i_bus_fields,
   input logic                        i_rsp_valid,
   input logic                        i_rsp_ready,
   input logic [RSP_FIELDS_WIDTH-1:0] i_rsp_fields,
   input logic                        i_cmd_ready
);
   a_bus_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_bus_valid && !i_bus_ready) |=> $stable(i_bus_fields));

   a_rsp_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_rsp_valid && !i_rsp_ready) |=> $stable(i_rsp_fields));

   a_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_cmd_ready && i_rsp_valid));
endmodule

// File: rtl/rggen_bus_initiator_timer.sv
// rggen_bus_initiator_timer: wait-state counter for an outstanding request.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : request is being issued this cycle (clears the count)
//   i_wait         : request outstanding and slave not ready (count one wait)
//   i_active       : request currently outstanding
//   o_timeout      : outstanding and at least TIMEOUT_CYCLES waits counted
module rggen_bus_initiator_timer #(
   parameter int TIMEOUT_CYCLES = 1,
   parameter int TIMEOUT_WIDTH  = 16
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_wait,
   input  logic i_active,
   output logic o_timeout
);
   localparam logic [TIMEOUT_WIDTH-1:0] THRESHOLD = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX = '1;

   logic [TIMEOUT_WIDTH-1:0] count_q;
   logic [TIMEOUT_WIDTH-1:0] count_d;

   // Next count: restart on a new request, saturate instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (i_start) begin
         count_d = '0;
      end else if (i_wait && (count_q != COUNT_MAX)) begin
         count_d = count_q + TIMEOUT_WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flag only while the request is still outstanding so it drops on completion.
   assign o_timeout = i_active && (count_q >= THRESHOLD);
endmodule

// File: rtl/rggen_bus_initiator.sv
// rggen_bus_initiator: single-outstanding command -> rggen bus -> response bridge.
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_cmd_* / o_cmd_ready : command stream (access, byte address, data, strobe)
//   o_rsp_* / i_rsp_ready : response stream (captured status and read data)
//   o_timeout             : request has waited at least TIMEOUT_CYCLES
//   bus_if                : rggen bus master port
module rggen_bus_initiator
   import rggen_rtl_pkg::*;
   import rggen_bus_initiator_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int ALIGN_CHECK    = 0,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TIMEOUT_WIDTH  = 16
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  rggen_access              i_cmd_access,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output rggen_status              o_rsp_status,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_timeout,
   rggen_bus_if.master              bus_if
);
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REQUEST  = 2'b01,
      RESPONSE = 2'b10
   } state_e;

   localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(lane_mask(BUS_WIDTH));

   state_e                   state_q;
   rggen_access              access_q;
   logic [ADDRESS_WIDTH-1:0] address_q;
   logic [BUS_WIDTH-1:0]     write_data_q;
   logic [BUS_WIDTH/8-1:0]   strobe_q;
   rggen_status              status_q;
   logic [BUS_WIDTH-1:0]     read_data_q;

   logic misaligned_s;
   logic issue_s;

   // Misaligned commands are answered locally and never reach the bus.
   assign misaligned_s = (ALIGN_CHECK != 0) && ((i_cmd_address & LANE_MASK) != '0);
   assign issue_s      = (state_q == IDLE) && i_cmd_valid && !misaligned_s;

   // Transaction FSM; command fields and response are captured here.
   // RGGEN_READ / RGGEN_OKAY are the all-zero encodings used as cleared values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         access_q     <= RGGEN_READ;
         address_q    <= '0;
         write_data_q <= '0;
         strobe_q     <= '0;
         status_q     <= RGGEN_OKAY;
         read_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_cmd_valid) begin
                  access_q     <= i_cmd_access;
                  address_q    <= i_cmd_address;
                  write_data_q <= i_cmd_write_data;
                  strobe_q     <= i_cmd_strobe;
                  if (misaligned_s) begin
                     status_q    <= RGGEN_SLAVE_ERROR;
                     read_data_q <= '0;
                     state_q     <= RESPONSE;
                  end else begin
                     state_q     <= REQUEST;
                  end
               end
            end
            REQUEST: begin
               // Read data is captured for writes too; consumers ignore it.
               if (bus_if.ready) begin
                  status_q    <= bus_if.status;
                  read_data_q <= bus_if.read_data;
                  state_q     <= RESPONSE;
               end
            end
            RESPONSE: begin
               if (i_rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready       = (state_q == IDLE);
   assign o_rsp_valid       = (state_q == RESPONSE);
   assign o_rsp_status      = status_q;
   assign o_rsp_read_data   = read_data_q;

   assign bus_if.valid      = (state_q == REQUEST);
   assign bus_if.access     = access_q;
   assign bus_if.address    = address_q;
   assign bus_if.write_data = write_data_q;
   assign bus_if.strobe     = strobe_q;

   // Timeout only observes: a request is never withdrawn once valid is up.
   if (TIMEOUT_CYCLES > 0) begin : g_timer
      rggen_bus_initiator_timer #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
      ) u_timer (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_start   (issue_s),
         .i_wait    ((state_q == REQUEST) && !bus_if.ready),
         .i_active  (state_q == REQUEST),
         .o_timeout (o_timeout)
      );
   end else begin : g_no_timer
      assign o_timeout = 1'b0;
   end

`ifdef RGGEN_ENABLE_SVA
   rggen_bus_initiator_sva #(
      .BUS_FIELDS_WIDTH (2 + ADDRESS_WIDTH + BUS_WIDTH + BUS_WIDTH/8),
      .RSP_FIELDS_WIDTH (2 + BUS_WIDTH)
   ) u_sva (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_bus_valid  (bus_if.valid),
      .i_bus_ready  (bus_if.ready),
      .i_bus_fields ({bus_if.access, bus_if.address, bus_if.write_data, bus_if.strobe}),
      .i_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .i_rsp_fields ({o_rsp_status, o_rsp_read_data}),
      .i_cmd_ready  (o_cmd_ready)
   );
`endif
endmodule
